// File: rtl/ram8_bist.sv
// March-style self-test master for a RAM8-compatible memory. It writes a background
// pattern, reads it back, writes the complement, reads that back, then reports the result.
module ram8_bist #(
  parameter int                ADDR_W = 3,
  parameter int                DATA_W = 16,
  parameter logic [DATA_W-1:0] BG     = 16'hA5C3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_phase,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_R0   = 3'd2,
    ST_W1   = 3'd3,
    ST_R1   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] A_LAST = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic                pass_q, pass_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic                fail_phase_q, fail_phase_d;
  logic [DATA_W-1:0]   p0, p1;

  // Mixing the address into the background makes address-decoder aliasing visible.
  assign p0 = BG ^ {{(DATA_W-ADDR_W){1'b0}}, a_q};
  assign p1 = ~p0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_phase_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      pass_q       <= pass_d;
      fail_addr_q  <= fail_addr_d;
      fail_phase_q <= fail_phase_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    pass_d       = pass_q;
    fail_addr_d  = fail_addr_q;
    fail_phase_d = fail_phase_q;
    busy         = 1'b0;
    done         = 1'b0;
    mem_load     = 1'b0;
    mem_address  = '0;
    mem_in       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_W0;
          a_d          = '0;
          pass_d       = 1'b0;
          fail_addr_d  = '0;
          fail_phase_d = 1'b0;
        end
      end
      ST_W0: begin
        busy        = 1'b1;
        mem_load    = 1'b1;
        mem_address = a_q;
        mem_in      = p0;
        a_d         = a_q + 1'b1;
        if (a_q == A_LAST) state_d = ST_R0;
      end
      // Reads compare against the combinational RAM output in the same cycle.
      ST_R0: begin
        busy        = 1'b1;
        mem_address = a_q;
        if (mem_out != p0) begin
          state_d      = ST_DONE;
          pass_d       = 1'b0;
          fail_addr_d  = a_q;
          fail_phase_d = 1'b0;
        end else begin
          a_d = a_q + 1'b1;
          if (a_q == A_LAST) state_d = ST_W1;
        end
      end
      ST_W1: begin
        busy        = 1'b1;
        mem_load    = 1'b1;
        mem_address = a_q;
        mem_in      = p1;
        a_d         = a_q + 1'b1;
        if (a_q == A_LAST) state_d = ST_R1;
      end
      ST_R1: begin
        busy        = 1'b1;
        mem_address = a_q;
        if (mem_out != p1) begin
          state_d      = ST_DONE;
          pass_d       = 1'b0;
          fail_addr_d  = a_q;
          fail_phase_d = 1'b1;
        end else begin
          a_d = a_q + 1'b1;
          if (a_q == A_LAST) begin
            state_d = ST_DONE;
            pass_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_phase = fail_phase_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ram8_bist.sv
// Directed bench for ram8_bist: a behavioural RAM8 with an injectable stuck-at-0 bit
// on the read path, and hand-computed latencies and results.
module tb_ram8_bist;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 16;
  localparam int N      = 8;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              busy, done, pass, fail_phase, mem_load;
  logic [ADDR_W-1:0] fail_addr, mem_address;
  logic [DATA_W-1:0] mem_in, mem_out;
  logic [2:0]        dbg_state;

  logic [DATA_W-1:0] ram [N];
  logic              flt_en;
  logic [ADDR_W-1:0] flt_addr;
  logic [DATA_W-1:0] flt_mask;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  ram8_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BG(16'hA5C3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .fail_phase(fail_phase),
    .mem_load(mem_load), .mem_address(mem_address), .mem_in(mem_in),
    .mem_out(mem_out), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM8 model: combinational read, write on rising edge
  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
  assign mem_out = ram[mem_address] &
                   ~((flt_en && mem_address == flt_addr) ? flt_mask : {DATA_W{1'b0}});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver: pulse start for one edge; returns at the negedge after that edge.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge until done is seen (bounded).
  // glitch_at >= 0 drives extra start pulses while busy.
  task automatic wait_done(input int glitch_at, output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (glitch_at >= 0) start = (i == glitch_at || i == glitch_at + 5);
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (glitch_at >= 0) start = 1'b0;
  endtask

  int bc;
  bit seen;
  int dcnt;

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    flt_en   = 1'b0;
    flt_addr = '0;
    flt_mask = '0;
    for (int i = 0; i < N; i++) ram[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_faddr", fail_addr, 0);
    chk("rst_load", mem_load, 0);
    chk("rst_mem_in", mem_in, 0);
    reset_n = 1'b1;

    // 1: fault-free run
    pulse_start();
    chk("w0_first_load", mem_load, 1);
    chk("w0_first_addr", mem_address, 0);
    chk("w0_first_in", mem_in, 16'hA5C3);
    wait_done(-1, bc, seen);
    chk("ok_done_seen", seen, 1);
    chk("ok_busy_cycles", bc, 32);
    chk("ok_pass", pass, 1);
    chk("ok_faddr", fail_addr, 0);
    chk("ok_ram0", ram[0], 16'h5A3C);
    chk("ok_ram7", ram[7], 16'h5A3B);
    for (int a = 0; a < N; a++) exp_q.push_back(~(16'hA5C3 ^ a[15:0]));
    for (int a = 0; a < N; a++) chk($sformatf("ok_ram_%0d", a), ram[a], exp_q.pop_front());
    @(negedge clk);
    chk("done_one_cycle", done, 0);

    // 2: bit 0 stuck at address 0 -> R0 fail
    flt_en = 1'b1; flt_addr = 3'd0; flt_mask = 16'h0001;
    pulse_start();
    wait_done(-1, bc, seen);
    chk("r0f_done_seen", seen, 1);
    chk("r0f_busy_cycles", bc, 9);
    chk("r0f_pass", pass, 0);
    chk("r0f_faddr", fail_addr, 0);
    chk("r0f_phase", fail_phase, 0);

    // 3: bit 1 stuck at address 2 -> R1 fail
    flt_addr = 3'd2; flt_mask = 16'h0002;
    pulse_start();
    wait_done(-1, bc, seen);
    chk("r1f_done_seen", seen, 1);
    chk("r1f_busy_cycles", bc, 27);
    chk("r1f_pass", pass, 0);
    chk("r1f_faddr", fail_addr, 2);
    chk("r1f_phase", fail_phase, 1);

    // 6: result holds in IDLE, clears on start, then fault-free run passes
    repeat (3) @(negedge clk);
    chk("hold_faddr", fail_addr, 2);
    chk("hold_phase", fail_phase, 1);
    flt_en = 1'b0;
    pulse_start();
    chk("clr_faddr", fail_addr, 0);
    chk("clr_phase", fail_phase, 0);
    chk("clr_pass", pass, 0);
    wait_done(-1, bc, seen);
    chk("b2b_busy_cycles", bc, 32);
    chk("b2b_pass", pass, 1);
    chk("b2b_faddr", fail_addr, 0);

    // 4: reset mid-test at busy cycle 12
    pulse_start();
    repeat (11) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_busy", busy, 0);
    chk("mid_load", mem_load, 0);
    chk("mid_pass", pass, 0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    chk("mid_no_done", dcnt, 0);
    pulse_start();
    wait_done(-1, bc, seen);
    chk("mid_rerun_cycles", bc, 32);
    chk("mid_rerun_pass", pass, 1);

    // 5a: start held high -> runs, then restarts right after DONE
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    wait_done(-1, bc, seen);
    chk("hold_run_cycles", bc, 32);
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_state", dbg_state, 0);
    @(negedge clk);
    chk("hold_restart_busy", busy, 1);
    wait_done(-1, bc, seen);
    chk("hold_rerun_cycles", bc, 32);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // 5b: start pulses while busy are ignored
    pulse_start();
    wait_done(4, bc, seen);
    chk("glitch_cycles", bc, 32);
    chk("glitch_pass", pass, 1);
    repeat (2) @(negedge clk);
    chk("glitch_no_restart", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram8_bist.md
Name: ram8_bist

Overview:
- Built-in self-test initiator that drives the RAM8 port set (load, address, in) and checks RAM8 `out`.
- Writes a background pattern, reads it back, writes the complement, reads that back, then reports pass/fail.
- Sits beside a RAM8 instance as its bus master during test. The attached RAM has a combinational read (`out` follows the selected word) and writes on the rising `clk` edge when load=1.

Parameters:
- ADDR_W, 3, RAM address width; word count N = 2^ADDR_W.
- DATA_W, 16, RAM word width.
- BG, 16'hA5C3, background pattern (DATA_W bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  begin test; sampled only in IDLE.
- busy  output  1  high while in W0/R0/W1/R1.
- done  output  1  one-cycle pulse in DONE state.
- pass  output  1  result of last completed test; valid from done, held until next start.
- fail_addr  output  ADDR_W  address of first mismatch; 0 if none.
- fail_phase  output  1  0 = mismatch in R0, 1 = mismatch in R1.
- mem_load  output  1  to RAM `load`.
- mem_address  output  ADDR_W  to RAM `address`.
- mem_in  output  DATA_W  to RAM `in`.
- mem_out  input  DATA_W  from RAM `out`.

Behaviour:
- Registers: state, address counter a (ADDR_W), pass, fail_addr, fail_phase.
- mem_load, mem_address, mem_in and busy are decoded combinationally from state and a.
- Pattern: p0(a) = BG ^ zero-extended a; p1(a) = ~p0(a).
- States: IDLE, W0, R0, W1, R1, DONE.
- Reset (reset_n=0 at an edge), including mid-test:
  - state=IDLE, a=0, pass=0, fail_addr=0, fail_phase=0.
  - Hence mem_load=0, mem_address=0, mem_in=0, busy=0, done=0 from that edge on.
  - A partially written RAM is left as-is.
- IDLE:
  - mem_load=0, mem_address=0, mem_in=0.
  - start=1 at an edge -> W0; a=0; pass, fail_addr, fail_phase cleared.
- W0:
  - mem_load=1, mem_address=a, mem_in=p0(a); a increments each edge.
  - At a=N-1 -> R0 with a=0 (a wraps).
- R0:
  - mem_load=0, mem_address=a; compare mem_out to p0(a) in the same cycle.
  - Mismatch -> DONE; pass=0, fail_addr=a, fail_phase=0 (test aborts at first mismatch).
  - Match -> a++; at a=N-1 with match -> W1 with a=0.
- W1: as W0 with p1(a); at a=N-1 -> R1 with a=0.
- R1:
  - As R0 against p1(a); mismatch sets fail_phase=1.
  - At a=N-1 with match -> DONE, pass=1.
- DONE:
  - done=1, busy=0, mem_load=0 for exactly one cycle, then -> IDLE.
  - start in DONE is ignored.
- start while busy is ignored; no restart.
- Latency, fault-free: start edge, then 4N busy cycles (32 at default), then the done cycle.
- Latency, mismatch in R0 at address k: N+k+1 busy cycles, then done.
- Final RAM content, fault-free: word a = p1(a).

Test Plan:
- Fault-free RAM8 model, defaults, start pulsed one cycle -> busy high exactly 32 cycles; done pulses once; pass=1, fail_addr=0; RAM[0]=16'h5A3C, RAM[7]=16'h5A3B.
- Bit 0 of mem_out forced 0 at address 0 -> R0 mismatch (p0(0)=16'hA5C3); done after 9 busy cycles; pass=0, fail_addr=0, fail_phase=0.
- Bit 1 of mem_out forced 0 at address 2 -> passes R0 (p0(2)=16'hA5C1), fails R1 (p1(2)=16'h5A3E); pass=0, fail_addr=2, fail_phase=1; done after 27 busy cycles.
- Reset mid-test: reset_n=0 for one edge at busy cycle 12 -> next cycle busy=0, mem_load=0, pass=0, no done pulse. Re-start then runs a full 32-cycle pass.
- start held high throughout -> test runs once (32 busy cycles, done) and restarts on the edge after DONE (IDLE sees start). start pulses during busy cause no restart and no cycle-count change.
- Back-to-back runs: a fault-run result (pass=0, fail_addr=2) holds until the next start edge, then clears; a subsequent fault-free run ends with pass=1, fail_addr=0.
